// File: rtl/ws2812_pkg.sv
// Shared types and default 50 MHz timing for the WS2812 frame driver.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_LATCH
  } state_t;

  localparam int WORD_W        = 24;
  localparam int DEF_T0H_CYC   = 20;     // 0.40 us high for a '0'
  localparam int DEF_T1H_CYC   = 40;     // 0.80 us high for a '1'
  localparam int DEF_BIT_CYC   = 63;     // 1.26 us bit period
  localparam int DEF_RESET_CYC = 15000;  // 300 us latch gap

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_word_tx.sv
// Serialises one 24-bit GRB word onto the WS2812 line, MSB first.
module ws2812_word_tx
  import ws2812_pkg::*;
#(
  parameter int T0H_CYC = DEF_T0H_CYC,
  parameter int T1H_CYC = DEF_T1H_CYC,
  parameter int BIT_CYC = DEF_BIT_CYC,
  parameter int CNT_W   = 8
) (
  input  logic              video_clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WORD_W-1:0] word,
  output logic              done,
  output logic              led_dout
);

  localparam logic [CNT_W-1:0] T0H_C      = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] T1H_C      = CNT_W'(T1H_CYC);
  localparam logic [CNT_W-1:0] BIT_LAST_C = CNT_W'(BIT_CYC - 1);

  logic              active_q, active_d;
  logic [4:0]        bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic              led_q, led_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  hi_len;

  assign hi_len   = shreg_q[WORD_W-1] ? T1H_C : T0H_C;
  assign led_dout = led_q;

  // Next-state for the bit sequencer; led level is precomputed for the next cycle
  always_comb begin
    active_d  = active_q;
    bit_idx_d = bit_idx_q;
    cyc_d     = cyc_q;
    led_d     = led_q;
    shreg_d   = shreg_q;
    done      = 1'b0;
    if (start) begin
      shreg_d   = word;
      bit_idx_d = 5'd23;
      cyc_d     = '0;
      active_d  = 1'b1;
      led_d     = 1'b1;
    end else if (active_q) begin
      if (cyc_q == BIT_LAST_C) begin
        cyc_d = '0;
        if (bit_idx_q == 5'd0) begin
          done     = 1'b1;
          active_d = 1'b0;
          led_d    = 1'b0;
        end else begin
          bit_idx_d = bit_idx_q - 5'd1;
          shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
          led_d     = 1'b1;
        end
      end else begin
        cyc_d = cyc_q + 1'b1;
        led_d = ((cyc_q + 1'b1) < hi_len);
      end
    end
  end

  // Control and line state, cleared asynchronously so the line drops at once
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      active_q  <= 1'b0;
      bit_idx_q <= '0;
      cyc_q     <= '0;
      led_q     <= 1'b0;
    end else begin
      active_q  <= active_d;
      bit_idx_q <= bit_idx_d;
      cyc_q     <= cyc_d;
      led_q     <= led_d;
    end
  end

  // Colour shift register; contents are don't-care until start loads it
  always_ff @(posedge video_clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: rtl/ws2812_frame_driver.sv
// Fetches a buffered frame word by word and drives it onto a WS2812 strip.
module ws2812_frame_driver
  import ws2812_pkg::*;
#(
  parameter int LED_NUM      = 444,
  parameter int T0H_CYC      = DEF_T0H_CYC,
  parameter int T1H_CYC      = DEF_T1H_CYC,
  parameter int BIT_CYC      = DEF_BIT_CYC,
  parameter int RESET_CYC    = DEF_RESET_CYC,
  parameter int RESP_TIMEOUT = 8
) (
  input  logic              rst,
  input  logic              video_clk,
  input  logic              wr_done,
  output logic              rd_req,
  input  logic [WORD_W-1:0] rgb_i,
  input  logic              rgb_i_val,
  output logic              led_dout,
  output logic              busy,
  output logic              resp_timeout
);

  localparam int CNT_W = $clog2(max_int(BIT_CYC, RESET_CYC) + 1);
  localparam int LED_W = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

  localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(RESP_TIMEOUT);
  localparam logic [CNT_W-1:0] LATCH_LAST_C = CNT_W'(RESET_CYC - 1);
  localparam logic [LED_W-1:0] LED_LAST_C   = LED_W'(LED_NUM - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0] led_cnt_q, led_cnt_d;
  logic             rd_req_q, rd_req_d;
  logic             busy_q, busy_d;
  logic             resp_timeout_q, resp_timeout_d;
  logic             tx_start;
  logic             tx_done;

  assign rd_req       = rd_req_q;
  assign busy         = busy_q;
  assign resp_timeout = resp_timeout_q;

  // Fetch FSM next-state; cnt_q is the wait timer in REQ/WAIT and the latch timer in LATCH
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    led_cnt_d      = led_cnt_q;
    rd_req_d       = 1'b0;
    busy_d         = busy_q;
    resp_timeout_d = 1'b0;
    tx_start       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (wr_done) begin
          state_d   = ST_REQ;
          led_cnt_d = '0;
          rd_req_d  = 1'b1;
          busy_d    = 1'b1;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        cnt_d   = cnt_q + 1'b1;
      end
      ST_WAIT: begin
        // A missing response still sends whatever sits on rgb_i, so the strip
        // always receives a full frame even when upstream drops the last valid.
        if (rgb_i_val || (cnt_q == TIMEOUT_C)) begin
          tx_start       = 1'b1;
          resp_timeout_d = ~rgb_i_val;
          state_d        = ST_SEND;
          cnt_d          = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_done) begin
          cnt_d = '0;
          if (led_cnt_q == LED_LAST_C) begin
            state_d = ST_LATCH;
          end else begin
            led_cnt_d = led_cnt_q + 1'b1;
            state_d   = ST_REQ;
            rd_req_d  = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (cnt_q == LATCH_LAST_C) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FSM, counters and registered outputs
  always_ff @(posedge video_clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      led_cnt_q      <= '0;
      rd_req_q       <= 1'b0;
      busy_q         <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      led_cnt_q      <= led_cnt_d;
      rd_req_q       <= rd_req_d;
      busy_q         <= busy_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  ws2812_word_tx #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC),
    .CNT_W   (CNT_W)
  ) u_word_tx (
    .video_clk (video_clk),
    .rst       (rst),
    .start     (tx_start),
    .word      (rgb_i),
    .done      (tx_done),
    .led_dout  (led_dout)
  );

endmodule

// File: tb/tb_ws2812_frame_driver.sv
// Scoreboard bench for ws2812_frame_driver with a small upstream frame-buffer model.
module tb_ws2812_frame_driver;

  localparam int LED_NUM      = 3;
  localparam int T0H_CYC      = 2;
  localparam int T1H_CYC      = 4;
  localparam int BIT_CYC      = 6;
  localparam int RESET_CYC    = 20;
  localparam int RESP_TIMEOUT = 8;

  logic        rst;
  logic        video_clk;
  logic        wr_done;
  logic        rd_req;
  logic [23:0] rgb_i;
  logic        rgb_i_val;
  logic        led_dout;
  logic        busy;
  logic        resp_timeout;

  ws2812_frame_driver #(
    .LED_NUM      (LED_NUM),
    .T0H_CYC      (T0H_CYC),
    .T1H_CYC      (T1H_CYC),
    .BIT_CYC      (BIT_CYC),
    .RESET_CYC    (RESET_CYC),
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) dut (
    .rst          (rst),
    .video_clk    (video_clk),
    .wr_done      (wr_done),
    .rd_req       (rd_req),
    .rgb_i        (rgb_i),
    .rgb_i_val    (rgb_i_val),
    .led_dout     (led_dout),
    .busy         (busy),
    .resp_timeout (resp_timeout)
  );

  initial video_clk = 1'b0;
  always #5 video_clk = ~video_clk;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];

  logic [23:0] frame_w [3];
  int suppress_idx = -1;

  // monitor state
  int cyc = 0, led_run = 0, rd_run = 0, rd_low = 0;
  bit rd_seen = 0, led_prev = 0, busy_prev = 0;
  int rd_cnt = 0, to_cnt = 0, led_hi_cyc = 0, led_rises = 0, busy_falls = 0;
  int last_led_fall = 0, busy_fall = 0, rd_rise = 0, to_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) exp_q.push_back(w[i] ? T1H_CYC : T0H_CYC);
  endtask

  task automatic push_frame();
    for (int i = 0; i < 3; i++) push_word(frame_w[i]);
  endtask

  task automatic tick();
    @(negedge video_clk);
    #1;
  endtask

  task automatic start_frame();
    @(posedge video_clk);
    #1 wr_done = 1'b1;
    @(posedge video_clk);
    #1 wr_done = 1'b0;
  endtask

  task automatic wait_busy_fall(input int bound);
    int b0 = busy_falls;
    int n = 0;
    while (busy_falls == b0 && n < bound) begin
      tick();
      n++;
    end
    if (busy_falls == b0) check("busy_fall_wait", 0, 1);
  endtask

  task automatic wait_rd(input int bound);
    int r0 = rd_cnt;
    int n = 0;
    while (rd_cnt == r0 && n < bound) begin
      tick();
      n++;
    end
    if (rd_cnt == r0) check("rd_req_wait", 0, 1);
  endtask

  // Upstream model: answers each rd_req with rgb_i_val three cycles later
  initial begin
    int cd = 0, addr = 0, req_addr = 0;
    rgb_i     = '0;
    rgb_i_val = 1'b0;
    forever begin
      @(posedge video_clk);
      #1;
      if (rst) begin
        cd = 0;
        addr = 0;
        rgb_i_val = 1'b0;
      end else begin
        rgb_i_val = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0 && req_addr != suppress_idx) rgb_i_val = 1'b1;
        end
        if (rd_req) begin
          rgb_i    = frame_w[addr];
          req_addr = addr;
          addr     = (addr == LED_NUM - 1) ? 0 : addr + 1;
          cd       = 3;
        end
      end
    end
  end

  // Monitor: measures pulses on the outputs and checks them against the scoreboard
  always @(negedge video_clk) begin
    cyc++;
    if (rst) begin
      led_run = 0; rd_run = 0; rd_seen = 0; led_prev = 0; busy_prev = 0;
    end else begin
      if (led_dout) begin
        led_run++;
        led_hi_cyc++;
        if (!led_prev) led_rises++;
      end else if (led_run > 0) begin
        if (exp_q.size() == 0) begin
          check("led_pulse_unexpected", led_run, 0);
        end else begin
          check("led_high_width", led_run, exp_q.pop_front());
        end
        led_run = 0;
        last_led_fall = cyc;
      end
      if (rd_req) begin
        if (rd_run == 0) begin
          rd_cnt++;
          rd_rise = cyc;
          if (rd_seen) check("rd_req_low_gap_ge3", (rd_low >= 3) ? 1 : 0, 1);
        end
        rd_run++;
      end else begin
        if (rd_run > 0) begin
          check("rd_req_width", rd_run, 1);
          rd_seen = 1;
          rd_low = 0;
        end
        rd_low++;
        rd_run = 0;
      end
      if (busy_prev && !busy) begin
        busy_falls++;
        busy_fall = cyc;
      end
      if (resp_timeout) begin
        to_cnt++;
        to_cyc = cyc;
        check("timeout_with_word_load", (led_dout && !led_prev) ? 1 : 0, 1);
      end
      led_prev  = led_dout;
      busy_prev = busy;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, h0, t0, k, k_rd, k_led, rises0;
    rst = 1'b1;
    wr_done = 1'b0;
    frame_w[0] = '0; frame_w[1] = '0; frame_w[2] = '0;
    repeat (3) tick();
    check("reset_rd_req", rd_req, 0);
    check("reset_led_dout", led_dout, 0);
    check("reset_busy", busy, 0);
    check("reset_resp_timeout", resp_timeout, 0);
    rst = 1'b0;

    // Idle with wr_done low
    r0 = rd_cnt; h0 = led_hi_cyc;
    repeat (1000) tick();
    check("idle_no_rd_req", rd_cnt - r0, 0);
    check("idle_led_low", led_hi_cyc - h0, 0);

    // Basic frame with start latency
    frame_w[0] = 24'hFF0000; frame_w[1] = 24'h000000; frame_w[2] = 24'hA5A5A5;
    push_frame();
    r0 = rd_cnt; t0 = to_cnt;
    start_frame();
    k = 0; k_rd = -1; k_led = -1;
    while (k < 50 && k_led < 0) begin
      tick();
      k++;
      if (rd_req && k_rd < 0) k_rd = k;
      if (led_dout) k_led = k;
    end
    check("start_rd_req_latency", k_rd, 1);
    check("start_led_latency", k_led, 5);
    wait_busy_fall(2000);
    check("s1_rd_req_count", rd_cnt - r0, 3);
    check("s1_scoreboard_empty", exp_q.size(), 0);
    check("s1_latch_low_to_busy_fall", busy_fall - last_led_fall, 2 + RESET_CYC);
    check("s1_no_timeout", to_cnt - t0, 0);

    // Suppressed valid on the final word
    frame_w[0] = 24'h123456; frame_w[1] = 24'h0F0F0F; frame_w[2] = 24'h00FF00;
    suppress_idx = 2;
    push_frame();
    r0 = rd_cnt; t0 = to_cnt;
    start_frame();
    wait_busy_fall(2000);
    check("s2_timeout_count", to_cnt - t0, 1);
    check("s2_timeout_delay", to_cyc - rd_rise, 1 + RESP_TIMEOUT);
    check("s2_scoreboard_empty", exp_q.size(), 0);
    check("s2_rd_req_count", rd_cnt - r0, 3);
    suppress_idx = -1;

    // wr_done held high: back-to-back frames
    frame_w[0] = 24'h800001; frame_w[1] = 24'h7E0000; frame_w[2] = 24'h0000C3;
    push_frame();
    push_frame();
    r0 = rd_cnt;
    @(posedge video_clk);
    #1 wr_done = 1'b1;
    wait_busy_fall(2000);
    check("s3_no_rd_req_in_latch", rd_cnt - r0, 3);
    wait_rd(10);
    check("s3_restart_after_idle", rd_rise - busy_fall, 1);
    check("s3_busy_back_high", busy, 1);
    wr_done = 1'b0;
    wait_busy_fall(2000);
    check("s3_rd_req_count", rd_cnt - r0, 6);
    check("s3_scoreboard_empty", exp_q.size(), 0);

    // wr_done drops after first rd_req
    frame_w[0] = 24'h0000FF; frame_w[1] = 24'hFFFFFF; frame_w[2] = 24'h5A0000;
    push_frame();
    r0 = rd_cnt;
    @(posedge video_clk);
    #1 wr_done = 1'b1;
    wait_rd(10);
    wr_done = 1'b0;
    wait_busy_fall(2000);
    check("s4_rd_req_count", rd_cnt - r0, 3);
    check("s4_scoreboard_empty", exp_q.size(), 0);
    repeat (100) tick();
    check("s4_no_new_frame", rd_cnt - r0, 3);
    check("s4_busy_low", busy, 0);

    // Reset in bit 10 of the second LED
    frame_w[0] = 24'hFFFFFF; frame_w[1] = 24'hFFFFFF; frame_w[2] = 24'hFFFFFF;
    push_frame();
    rises0 = led_rises;
    @(posedge video_clk);
    #1 wr_done = 1'b1;
    wait_rd(10);
    wr_done = 1'b0;
    k = 0;
    while (led_rises < rises0 + 24 + 14 && k < 1000) begin
      tick();
      k++;
    end
    check("s5_reached_bit10", led_rises - rises0, 24 + 14);
    check("s5_mid_bit_high", led_dout, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("s5_rst_led_dout", led_dout, 0);
    check("s5_rst_rd_req", rd_req, 0);
    check("s5_rst_busy", busy, 0);
    repeat (3) tick();
    rst = 1'b0;
    r0 = rd_cnt; h0 = led_hi_cyc;
    repeat (50) tick();
    check("s5_quiet_rd_req", rd_cnt - r0, 0);
    check("s5_quiet_led", led_hi_cyc - h0, 0);
    frame_w[0] = 24'h00000F; frame_w[1] = 24'hF00000; frame_w[2] = 24'h3C3C3C;
    push_frame();
    start_frame();
    wait_busy_fall(2000);
    check("s5_rd_req_count", rd_cnt - r0, 3);
    check("s5_scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812_frame_driver.md
# ws2812_frame_driver

Downstream consumer of the border pixel-mean ordering stage. Once a complete ordered frame of LED colours is buffered upstream (`wr_done` high), it fetches colours one at a time with single-cycle `rd_req` pulses. Each returned 24-bit GRB word is serialised onto the one-wire WS2812 LED strip, and the strip is latched with a reset gap after the last LED.

## Interface
- `LED_NUM`, default 444: LEDs per frame; must equal the upstream border pixel count.
- `T0H_CYC`, default 20: `video_clk` cycles high for a '0' bit.
- `T1H_CYC`, default 40: cycles high for a '1' bit.
- `BIT_CYC`, default 63: total cycles per bit; must be greater than `T1H_CYC`, and `T1H_CYC` greater than `T0H_CYC`.
- `RESET_CYC`, default 15000: low cycles after the last LED (latch gap).
- `RESP_TIMEOUT`, default 8: maximum cycles to wait for `rgb_i_val` after `rd_req`.
- `rst` in 1: asynchronous, active-high reset.
- `video_clk` in 1: clock.
- `wr_done` in 1: upstream frame ready; level.
- `rd_req` out 1: fetch pulse, exactly one cycle wide.
- `rgb_i` in 24: colour word as {G[7:0], R[7:0], B[7:0]}.
- `rgb_i_val` in 1: `rgb_i` valid, expected 3 cycles after `rd_req`.
- `led_dout` out 1: WS2812 serial data.
- `busy` out 1: high from frame start through the end of the reset gap.
- `resp_timeout` out 1: one-cycle pulse when a fetch times out.

## Operation
- FSM states are IDLE, REQ, WAIT, SEND, LATCH.
- IDLE
  - `led_dout` is 0.
  - `wr_done` is sampled only in this state; `wr_done`=1 → REQ, LED counter cleared.
- REQ
  - `rd_req`=1 for this single cycle, then → WAIT.
  - `rd_req` is always low for at least 3 cycles between pulses, so every pulse is a fresh rising edge upstream.
- WAIT
  - Wait counter counts cycles from REQ.
  - `rgb_i_val`=1 → `rgb_i` loaded into the shift register, → SEND.
  - Counter reaching `RESP_TIMEOUT` without `rgb_i_val` → `rgb_i` loaded anyway, `resp_timeout` pulses, → SEND.
  - The timeout covers upstream suppressing `rgb_i_val` on the final word of a frame.
- SEND
  - 24 bits are sent, bit 23 first.
  - Each bit lasts `BIT_CYC` cycles: `led_dout` high for `T1H_CYC` if the bit is 1, else `T0H_CYC`, then low for the remainder.
  - After bit 0: LED counter equals `LED_NUM`-1 → LATCH; otherwise counter +1, → REQ.
- The inter-word REQ+WAIT time extends the low phase of bit 0 by at most 1+`RESP_TIMEOUT` cycles, which is within WS2812 tolerance.
- LATCH
  - `led_dout`=0 for `RESET_CYC` cycles, then → IDLE.
  - A new frame starts only if `wr_done` is high on return to IDLE.
- Counter widths:
  - bit index: 5 bits.
  - cycle counter: clog2 of max(`BIT_CYC`, `RESET_CYC`)+1.
  - LED counter: clog2(`LED_NUM`).
  - All counters wrap to 0 on state exit, never by overflow.
- `wr_done` falling mid-frame is ignored; the frame completes.
- Reset mid-frame: all outputs go low immediately and the FSM returns to IDLE. Upstream shares `rst`, so both sides restart at address 0.

## Timing
- Reset values: `rd_req`=0, `led_dout`=0, `busy`=0, `resp_timeout`=0; FSM in IDLE.
- All outputs are registered.
- Frame start:
  - `wr_done`=1 sampled at edge n → `rd_req`=1 during cycle n+1, `busy`=1 from n+1.
  - Nominal `rgb_i_val` arrives in cycle n+4 and is latched at the end of n+4.
  - The first `led_dout` rising edge is at the start of cycle n+5.
- The high time of each bit is exact (`T0H_CYC` or `T1H_CYC` cycles). The bit period is exactly `BIT_CYC`, except bit 0 of non-final words, which includes the fetch gap.
- `busy` falls in the cycle the FSM re-enters IDLE.
- `resp_timeout` is high in the same cycle the timed-out word is loaded.

## Structure
- Package `ws2812_pkg`: FSM state enum, and default timing constants (`T0H_CYC`, `T1H_CYC`, `BIT_CYC`, `RESET_CYC`) for 50 MHz.
- Sub-module `ws2812_word_tx`:
  - Inputs: `start` and `word`[23:0]. Outputs: `done` pulse and `led_dout`.
  - Owns the shift register, bit index and bit-cycle counter.
  - The top level keeps the fetch FSM, LED counter and latch timer.

## Test plan
Parameters for all scenarios: `LED_NUM`=3, `T0H_CYC`=2, `T1H_CYC`=4, `BIT_CYC`=6, `RESET_CYC`=20, `RESP_TIMEOUT`=8; the upstream model returns `rgb_i_val` 3 cycles after `rd_req`.
1. Words 0xFF0000, 0x000000, 0xA5A5A5 → exactly 3 `rd_req` pulses, each 1 cycle wide with ≥3 low cycles between.
   - `led_dout` high widths: 8×4 then 16×2; 24×2; then the 0xA5 pattern (4,2,4,2,2,4,2,4)×3.
   - Then 20 low cycles; `busy` falls after them.
2. Upstream suppresses `rgb_i_val` for word 3 → after 8 wait cycles `resp_timeout` pulses once and the word on `rgb_i` is still transmitted.
3. `wr_done` held high continuously → second frame's `rd_req` begins the cycle after LATCH ends.
   - No `rd_req` occurs during LATCH.
4. `wr_done` drops after the first `rd_req` → all 3 LEDs are still sent; no new frame starts.
5. `rst` asserted in the middle of bit 10 of LED 2 → `led_dout`, `rd_req` and `busy` are 0 immediately.
   - After release, nothing happens until `wr_done`; the next frame starts at LED 0.
6. `wr_done`=0 after reset for 1000 cycles → no `rd_req`; `led_dout` stays 0.
